// File: rtl/io_pad_responder_if.sv
// Controller snapshot inputs and status outputs of the pad-side 1-wire responder.
// The responder takes the slave view; the host-side bench or SoC takes the master view.
interface io_pad_responder_if;
   logic [127:0] cont_key;
   logic [127:0] cont_joy;
   logic [63:0]  cont_trig;
   logic         busy;
   logic         poll_seen;
   logic         heartbeat_seen;
   logic         cmd_unknown;
   logic         rx_abort;
   logic [31:0]  last_cmd;
   logic [15:0]  poll_count;

   modport slave (
      input  cont_key, cont_joy, cont_trig,
      output busy, poll_seen, heartbeat_seen, cmd_unknown, rx_abort, last_cmd, poll_count
   );

   modport master (
      output cont_key, cont_joy, cont_trig,
      input  busy, poll_seen, heartbeat_seen, cmd_unknown, rx_abort, last_cmd, poll_count
   );
endinterface

// File: rtl/io_pad_responder.sv
// Pad-side end of the 1-wire controller link: decodes host command words and answers a
// poll with a 12-word snapshot of the four controller states.
module io_pad_responder #(
   parameter int          BITLEN        = 60,
   parameter int          SAMPLE_PT     = 26,
   parameter int          RX_END        = 50,
   parameter int          RX_TIMEOUT    = 1023,
   parameter int          TURNAROUND    = 256,
   parameter int          WORD_GAP      = 16,
   parameter logic [31:0] CMD_POLL      = 32'h4A10000C,
   parameter logic [31:0] CMD_HEARTBEAT = 32'h4AFE0000
) (
   input  logic               clk,
   input  logic               reset_n,
   inout  wire                pad_1wire,
   io_pad_responder_if.slave  bus
);

   localparam logic [8:0] SAMPLE_C   = 9'(SAMPLE_PT);
   localparam logic [8:0] RX_END_C   = 9'(RX_END);
   localparam logic [8:0] THIRD_C    = 9'(BITLEN / 3);
   localparam logic [8:0] TWO_C      = 9'((2 * BITLEN) / 3);
   localparam logic [8:0] BIT_LAST_C = 9'(BITLEN - 1);
   localparam logic [8:0] TA_LAST_C  = 9'(TURNAROUND - 1);
   localparam logic [8:0] GAP_LAST_C = 9'(WORD_GAP - 1);
   localparam logic [9:0] TMO_C      = 10'(RX_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_RX_BIT, S_RX_WAITEDGE, S_DECODE, S_TURNAROUND, S_TX_BIT, S_TX_GAP
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         sync_q, sync_d;
   logic [8:0]         cnt_q, cnt_d;
   logic [4:0]         bit_q, bit_d;
   logic [3:0]         word_q, word_d;
   logic [9:0]         tmo_q, tmo_d;
   logic [31:0]        rx_sh_q, rx_sh_d;
   logic [31:0]        tx_sh_q, tx_sh_d;
   logic [11:0][31:0]  snap_q, snap_d;
   logic [31:0]        last_cmd_q, last_cmd_d;
   logic [15:0]        poll_count_q, poll_count_d;
   logic               poll_seen_q, poll_seen_d;
   logic               hb_seen_q, hb_seen_d;
   logic               unknown_q, unknown_d;
   logic               abort_q, abort_d;
   logic               busy_q, busy_d;
   logic               pad_oe_q, pad_oe_d;
   logic               pad_val_q, pad_val_d;
   logic               pad_s;
   logic               fall_s;

   // sync_q[0] is the metastability catcher; [1] is the synchronised line, [2] its previous value
   assign pad_s  = sync_q[1];
   assign fall_s = sync_q[2] & ~sync_q[1];

   assign pad_1wire = pad_oe_q ? pad_val_q : 1'bz;

   assign bus.busy           = busy_q;
   assign bus.poll_seen      = poll_seen_q;
   assign bus.heartbeat_seen = hb_seen_q;
   assign bus.cmd_unknown    = unknown_q;
   assign bus.rx_abort       = abort_q;
   assign bus.last_cmd       = last_cmd_q;
   assign bus.poll_count     = poll_count_q;

   // Next-state logic; line drive is derived from the next state so it aligns with state_q
   always_comb begin
      state_d      = state_q;
      sync_d       = {sync_q[1:0], pad_1wire};
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      word_d       = word_q;
      tmo_d        = tmo_q;
      rx_sh_d      = rx_sh_q;
      tx_sh_d      = tx_sh_q;
      snap_d       = snap_q;
      last_cmd_d   = last_cmd_q;
      poll_count_d = poll_count_q;
      poll_seen_d  = 1'b0;
      hb_seen_d    = 1'b0;
      unknown_d    = 1'b0;
      abort_d      = 1'b0;
      pad_oe_d     = 1'b0;
      pad_val_d    = 1'b1;

      case (state_q)
         S_IDLE: begin
            cnt_d  = 9'd0;
            bit_d  = 5'd0;
            word_d = 4'd0;
            tmo_d  = 10'd0;
            if (fall_s) begin
               state_d = S_RX_BIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RX_BIT: begin
            cnt_d = cnt_q + 9'd1;
            tmo_d = 10'd0;
            if (cnt_q == SAMPLE_C) begin
               rx_sh_d = {rx_sh_q[30:0], pad_s};
            end else begin
               rx_sh_d = rx_sh_q;
            end
            if (cnt_q == RX_END_C) begin
               cnt_d = 9'd0;
               bit_d = bit_q + 5'd1;
               if (bit_q == 5'd31) begin
                  state_d = S_DECODE;
               end else begin
                  state_d = S_RX_WAITEDGE;
               end
            end else begin
               state_d = S_RX_BIT;
            end
         end
         S_RX_WAITEDGE: begin
            if (fall_s) begin
               cnt_d   = 9'd0;
               tmo_d   = 10'd0;
               state_d = S_RX_BIT;
            end else if (tmo_q == TMO_C) begin
               abort_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + 10'd1;
            end
         end
         S_DECODE: begin
            last_cmd_d = rx_sh_q;
            cnt_d      = 9'd0;
            if (rx_sh_q == CMD_POLL) begin
               for (int n = 0; n < 4; n++) begin
                  snap_d[3*n]     = bus.cont_key[32*n +: 32];
                  snap_d[3*n + 1] = bus.cont_joy[32*n +: 32];
                  snap_d[3*n + 2] = {16'h0000, bus.cont_trig[16*n +: 16]};
               end
               poll_count_d = poll_count_q + 16'd1;
               poll_seen_d  = 1'b1;
               state_d      = S_TURNAROUND;
            end else if (rx_sh_q == CMD_HEARTBEAT) begin
               hb_seen_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               unknown_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_TURNAROUND: begin
            if (cnt_q == TA_LAST_C) begin
               cnt_d   = 9'd0;
               bit_d   = 5'd0;
               word_d  = 4'd0;
               tx_sh_d = snap_q[0];
               state_d = S_TX_BIT;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         S_TX_BIT: begin
            if (cnt_q == BIT_LAST_C) begin
               cnt_d   = 9'd0;
               tx_sh_d = {tx_sh_q[30:0], 1'b0};
               bit_d   = bit_q + 5'd1;
               if (bit_q == 5'd31) begin
                  state_d = S_TX_GAP;
               end else begin
                  state_d = S_TX_BIT;
               end
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         S_TX_GAP: begin
            if (cnt_q == GAP_LAST_C) begin
               cnt_d = 9'd0;
               bit_d = 5'd0;
               if (word_q == 4'd11) begin
                  state_d = S_IDLE;
               end else begin
                  word_d  = word_q + 4'd1;
                  tx_sh_d = snap_q[word_q + 4'd1];
                  state_d = S_TX_BIT;
               end
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Only the final turnaround clock is driven high, giving the host a clean first falling edge
      case (state_d)
         S_TURNAROUND: begin
            pad_oe_d  = (cnt_d == TA_LAST_C);
            pad_val_d = 1'b1;
         end
         S_TX_BIT: begin
            pad_oe_d = 1'b1;
            if (cnt_d < THIRD_C) begin
               pad_val_d = 1'b0;
            end else if (cnt_d < TWO_C) begin
               pad_val_d = tx_sh_d[31];
            end else begin
               pad_val_d = 1'b1;
            end
         end
         S_TX_GAP: begin
            pad_oe_d  = 1'b1;
            pad_val_d = 1'b1;
         end
         default: begin
            pad_oe_d  = 1'b0;
            pad_val_d = 1'b1;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         sync_q       <= 3'b111;
         cnt_q        <= 9'd0;
         bit_q        <= 5'd0;
         word_q       <= 4'd0;
         tmo_q        <= 10'd0;
         rx_sh_q      <= 32'h0;
         tx_sh_q      <= 32'h0;
         snap_q       <= '0;
         last_cmd_q   <= 32'h0;
         poll_count_q <= 16'h0;
         poll_seen_q  <= 1'b0;
         hb_seen_q    <= 1'b0;
         unknown_q    <= 1'b0;
         abort_q      <= 1'b0;
         busy_q       <= 1'b0;
         pad_oe_q     <= 1'b0;
         pad_val_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         word_q       <= word_d;
         tmo_q        <= tmo_d;
         rx_sh_q      <= rx_sh_d;
         tx_sh_q      <= tx_sh_d;
         snap_q       <= snap_d;
         last_cmd_q   <= last_cmd_d;
         poll_count_q <= poll_count_d;
         poll_seen_q  <= poll_seen_d;
         hb_seen_q    <= hb_seen_d;
         unknown_q    <= unknown_d;
         abort_q      <= abort_d;
         busy_q       <= busy_d;
         pad_oe_q     <= pad_oe_d;
         pad_val_q    <= pad_val_d;
      end
   end

endmodule

// File: tb/tb_io_pad_responder.sv
// Directed bench for io_pad_responder: a host BFM sends command words on the 1-wire line
// and decodes the poll response; non-poll commands are table-driven.
module tb_io_pad_responder;

   typedef struct {
      logic [31:0] cmd;
      int          exp_hb;
      int          exp_unk;
   } vec_t;

   logic clk;
   logic reset_n;
   logic host_oe;
   logic host_val;
   wire  pad_1wire;

   int n_checks;
   int n_fail;
   int n_poll, n_hb, n_unk, n_abort;
   int b_poll, b_hb, b_unk, b_abort;

   io_pad_responder_if bus ();

   io_pad_responder dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .pad_1wire (pad_1wire),
      .bus       (bus)
   );

   pullup (pad_1wire);
   assign pad_1wire = host_oe ? host_val : 1'bz;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters: a stuck pulse shows up as more than one count
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.poll_seen)      n_poll++;
         if (bus.heartbeat_seen) n_hb++;
         if (bus.cmd_unknown)    n_unk++;
         if (bus.rx_abort)       n_abort++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic snap_counts();
      b_poll = n_poll; b_hb = n_hb; b_unk = n_unk; b_abort = n_abort;
   endtask

   // Host bit cell: 20 clks low, 20 clks data, 20 clks released
   task automatic send_bits(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         host_oe = 1'b1; host_val = 1'b0;
         repeat (20) @(negedge clk);
         host_val = w[31 - i];
         repeat (20) @(negedge clk);
         host_oe = 1'b0; host_val = 1'b1;
         repeat (19) @(negedge clk);
      end
   endtask

   task automatic wait_fall(output bit ok);
      int k;
      k = 0;
      while (pad_1wire !== 1'b0 && k < 600) begin
         @(negedge clk);
         k++;
      end
      ok = (k < 600);
   endtask

   // Receive n response bits, shifting them MSB first into acc
   task automatic recv_bits(input int n, inout logic [31:0] acc, inout bit ok);
      bit got;
      for (int i = 0; i < n; i++) begin
         if (ok) begin
            wait_fall(got);
            if (!got) begin
               ok = 1'b0;
               check("rx_edge_timeout", 32'd0, 32'd1);
            end else begin
               repeat (30) @(negedge clk);
               acc = {acc[30:0], pad_1wire};
               repeat (25) @(negedge clk);
            end
         end
      end
   endtask

   task automatic check_no_drive(input string name, input int clks);
      int bad;
      bad = 0;
      repeat (clks) begin
         @(negedge clk);
         if (pad_1wire !== 1'b1 || dut.pad_oe_q !== 1'b0) bad++;
      end
      check(name, 32'(bad), 32'd0);
   endtask

   vec_t        vecs [6];
   logic [31:0] exp_words [12];
   logic [31:0] acc;
   bit          ok;
   int          k;

   initial begin
      vecs[0] = '{cmd: 32'h4AFE0000, exp_hb: 1, exp_unk: 0};
      vecs[1] = '{cmd: 32'h12345678, exp_hb: 0, exp_unk: 1};
      vecs[2] = '{cmd: 32'h4A10000D, exp_hb: 0, exp_unk: 1};
      vecs[3] = '{cmd: 32'h00000000, exp_hb: 0, exp_unk: 1};
      vecs[4] = '{cmd: 32'hFFFFFFFF, exp_hb: 0, exp_unk: 1};
      vecs[5] = '{cmd: 32'h4AFE0001, exp_hb: 0, exp_unk: 1};

      for (int i = 0; i < 12; i++) exp_words[i] = 32'h0;
      exp_words[0]  = 32'h00000001;
      exp_words[1]  = 32'h80007F7F;
      exp_words[11] = 32'h0000ABCD;

      n_checks = 0; n_fail = 0;
      n_poll = 0; n_hb = 0; n_unk = 0; n_abort = 0;
      host_oe = 1'b0; host_val = 1'b1;
      bus.cont_key  = {96'h0, 32'h00000001};
      bus.cont_joy  = {96'h0, 32'h80007F7F};
      bus.cont_trig = {16'hABCD, 48'h0};
      reset_n = 1'b0;
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_last_cmd", bus.last_cmd, 32'h0);
      check("reset_poll_count", 32'(bus.poll_count), 32'd0);
      check("reset_pulses", 32'({bus.poll_seen, bus.heartbeat_seen, bus.cmd_unknown, bus.rx_abort}), 32'd0);
      check("reset_line_z", 32'({pad_1wire, dut.pad_oe_q}), 32'd2);

      // Poll 1: key1 changes during word 0, response must keep the snapshot value
      snap_counts();
      send_bits(32'h4A10000C, 32);
      repeat (5) @(negedge clk);
      check("poll1_seen", 32'(n_poll - b_poll), 32'd1);
      check("poll1_count", 32'(bus.poll_count), 32'd1);
      check("poll1_last_cmd", bus.last_cmd, 32'h4A10000C);
      check("poll1_busy", 32'(bus.busy), 32'd1);
      ok = 1'b1;
      acc = 32'h0;
      recv_bits(1, acc, ok);
      bus.cont_key = {96'h0, 32'hFFFFFFFF};
      recv_bits(31, acc, ok);
      check("poll1_word0", acc, exp_words[0]);
      for (int w = 1; w < 12; w++) begin
         acc = 32'h0;
         recv_bits(32, acc, ok);
         check($sformatf("poll1_word%0d", w), acc, exp_words[w]);
      end
      k = 0;
      while (bus.busy !== 1'b0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("poll1_end_idle", 32'(bus.busy), 32'd0);
      check("poll1_end_line_z", 32'({pad_1wire, dut.pad_oe_q}), 32'd2);

      // Non-poll commands from the table
      for (int i = 0; i < 6; i++) begin
         snap_counts();
         send_bits(vecs[i].cmd, 32);
         repeat (10) @(negedge clk);
         check($sformatf("v%0d_hb", i), 32'(n_hb - b_hb), 32'(vecs[i].exp_hb));
         check($sformatf("v%0d_unk", i), 32'(n_unk - b_unk), 32'(vecs[i].exp_unk));
         check($sformatf("v%0d_poll", i), 32'(n_poll - b_poll), 32'd0);
         check($sformatf("v%0d_last_cmd", i), bus.last_cmd, vecs[i].cmd);
         check($sformatf("v%0d_poll_count", i), 32'(bus.poll_count), 32'd1);
         check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd0);
         check_no_drive($sformatf("v%0d_no_drive", i), 300);
      end

      // Truncated word: abort after the wait-edge timeout, last_cmd untouched
      snap_counts();
      send_bits(32'h4A10000C, 10);
      k = 0;
      while (n_abort == b_abort && k < 1500) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      check("abort_seen", 32'(n_abort - b_abort), 32'd1);
      check("abort_not_early", 32'(k > 1000), 32'd1);
      check("abort_no_decode", 32'((n_poll - b_poll) + (n_hb - b_hb) + (n_unk - b_unk)), 32'd0);
      check("abort_last_cmd", bus.last_cmd, 32'h4AFE0001);
      check("abort_busy", 32'(bus.busy), 32'd0);

      // Poll 2 with the counter at FFFF: wraps, and carries the new key1
      @(negedge clk);
      force dut.poll_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.poll_count_q;
      snap_counts();
      send_bits(32'h4A10000C, 32);
      repeat (5) @(negedge clk);
      check("poll2_seen", 32'(n_poll - b_poll), 32'd1);
      check("poll2_count_wrap", 32'(bus.poll_count), 32'd0);
      exp_words[0] = 32'hFFFFFFFF;
      ok = 1'b1;
      for (int w = 0; w < 5; w++) begin
         acc = 32'h0;
         recv_bits(32, acc, ok);
         check($sformatf("poll2_word%0d", w), acc, exp_words[w]);
      end

      // Reset while word 5 is being driven low: line must release at once
      wait_fall(ok);
      check("poll2_word5_start", 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      check("mid_tx_driving_low", 32'(pad_1wire), 32'd0);
      snap_counts();
      #1 reset_n = 1'b0;
      #1;
      check("reset_mid_tx_line_z", 32'(pad_1wire), 32'd1);
      check("reset_mid_tx_busy", 32'(bus.busy), 32'd0);
      check("reset_mid_tx_count", 32'(bus.poll_count), 32'd0);
      check("reset_mid_tx_last_cmd", bus.last_cmd, 32'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      check_no_drive("after_reset_no_drive", 200);
      check("after_reset_no_pulse", 32'((n_poll - b_poll) + (n_hb - b_hb) + (n_unk - b_unk) + (n_abort - b_abort)), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
